// File: rtl/pipelined_addsub_pkg.sv
// Shared defaults and helpers for the pipelined adder/subtractor.
package pipelined_addsub_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SEG   = 4;

    // Number of ripple segments (= pipeline stages) for a given width/segment size.
    function automatic int unsigned stage_count(input int unsigned width, input int unsigned seg);
        return (seg == 0) ? 0 : (width / seg);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG-bit ripple segment: s/co = x + y + ci. The only arithmetic in the block.
module addsub_seg
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned SEG = DEF_SEG
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    localparam int unsigned SW = SEG + 1;

    logic [SEG:0] total;

    assign total   = {1'b0, x} + {1'b0, y} + SW'(ci);
    assign {co, s} = total;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit ripple segment per
// stage, carry registered between stages, valid/ready on both sides with a
// single global stall.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTG = stage_count(WIDTH, SEG);
    localparam int unsigned LAST = NSTG - 1;

    // Elaboration-time parameter sanity.
    if ((SEG < 1) || (SEG > WIDTH)) begin : g_chk_seg_range
        $error("pipelined_addsub: SEG must satisfy 1 <= SEG <= WIDTH");
    end else if ((WIDTH % SEG) != 0) begin : g_chk_seg_multiple
        $error("pipelined_addsub: WIDTH must be a multiple of SEG");
    end

    // Per-stage registers; index k holds the state captured by stage k+1.
    logic             vld_q [NSTG];
    logic             cy_q  [NSTG];
    logic [WIDTH-1:0] res_q [NSTG];
    logic [WIDTH-1:0] a_q   [NSTG];
    logic [WIDTH-1:0] b_q   [NSTG];

    logic             en;
    logic [WIDTH-1:0] b_cond;

    // Subtraction is a + ~b + 1: invert B here, the +1 enters as stage-1 carry-in.
    assign b_cond = sub ? ~b : b;

    // Whole pipe advances unless a result is waiting on a stalled consumer.
    assign en       = out_ready | ~vld_q[LAST];
    assign in_ready = en;

    for (genvar i = 0; i < NSTG; i++) begin : g_stg
        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] b_d;
        logic [WIDTH-1:0] res_p;
        logic [WIDTH-1:0] res_d;
        logic             ci_d;
        logic             vld_d;
        logic [SEG-1:0]   s_w;
        logic             co_w;

        if (i == 0) begin : g_first
            assign a_d   = a;
            assign b_d   = b_cond;
            assign res_p = '0;
            assign ci_d  = sub;
            assign vld_d = in_valid;
        end else begin : g_next
            assign a_d   = a_q[i-1];
            assign b_d   = b_q[i-1];
            assign res_p = res_q[i-1];
            assign ci_d  = cy_q[i-1];
            assign vld_d = vld_q[i-1];
        end

        addsub_seg #(
            .SEG (SEG)
        ) u_seg (
            .x  (a_d[i*SEG +: SEG]),
            .y  (b_d[i*SEG +: SEG]),
            .ci (ci_d),
            .s  (s_w),
            .co (co_w)
        );

        // Append this stage's segment to the partial result from upstream.
        always_comb begin
            res_d                 = res_p;
            res_d[i*SEG +: SEG]   = s_w;
        end

        // Stage register: advances together with every other stage on en, bubbles included.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q[i] <= 1'b0;
                cy_q[i]  <= 1'b0;
                res_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
            end else if (en) begin
                vld_q[i] <= vld_d;
                cy_q[i]  <= co_w;
                res_q[i] <= res_d;
                a_q[i]   <= a_d;
                b_q[i]   <= b_d;
            end
        end
    end

    // Outputs come straight from the final stage register.
    assign out_valid = vld_q[LAST];
    assign sum       = res_q[LAST];
    assign cout      = cy_q[LAST];
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                       (res_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
